// File: rtl/spawn_out_writer.sv
// Spawn descriptor writer into the spawnout ring plus completion reader from the spawnin ring.
// The two FSMs share nothing but clock and reset and may access their rings in the same cycle.
module spawn_out_writer #(
  parameter int unsigned SPAWNOUT_SIZE = 1024,
  parameter int unsigned SPAWNIN_SIZE  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic        in_last,
  output logic        cmpl_valid,
  input  logic        cmpl_ready,
  output logic [63:0] cmpl_tid,
  output logic [63:0] cmpl_ptid,
  output logic        proto_err,
  output logic [31:0] spawnout_addr,
  output logic        spawnout_en,
  output logic [7:0]  spawnout_wr,
  output logic [63:0] spawnout_din,
  input  logic [63:0] spawnout_dout,
  output logic [31:0] spawnin_addr,
  output logic        spawnin_en,
  output logic [7:0]  spawnin_wr,
  output logic [63:0] spawnin_din,
  input  logic [63:0] spawnin_dout
);
  localparam int unsigned OW = $clog2(SPAWNOUT_SIZE);
  localparam int unsigned IW = $clog2(SPAWNIN_SIZE);

  typedef enum logic [1:0] {W_IDLE, W_CHECK, W_BODY, W_HEADER} wstate_e;
  typedef enum logic [2:0] {R_POLL, R_TID, R_PTID, R_CLEAR, R_OUT} rstate_e;

  wstate_e       wstate_q, wstate_d;
  logic [63:0]   hdr_q, hdr_d;
  logic [6:0]    nslots_q, nslots_d;
  logic [6:0]    k_q, k_d;
  logic [OW-1:0] wr_idx_q, wr_idx_d;
  logic          chk_pend_q, chk_pend_d;
  logic          perr_q, perr_d;
  logic [OW-1:0] so_idx;
  logic          in_ready_c;
  logic [7:0]    so_wr_c;
  logic          last_beat;

  rstate_e       rstate_q, rstate_d;
  logic [IW-1:0] rd_idx_q, rd_idx_d;
  logic [63:0]   tid_q, tid_d, ptid_q, ptid_d;
  logic          poll_vld_q, poll_vld_d;
  logic [IW-1:0] si_idx;
  logic [7:0]    si_wr_c;
  logic          cmpl_valid_c;

  logic [7:0]    n_args, n_deps, n_cops;
  logic          hdr_bad;
  logic [6:0]    hdr_slots;
  logic          unused_bits;

  assign n_args    = in_data[55:48];
  assign n_deps    = in_data[47:40];
  assign n_cops    = in_data[39:32];
  assign hdr_bad   = (n_args == 8'd0) || (n_args > 8'd15) || (n_deps > 8'd15) || (n_cops > 8'd15);
  assign hdr_slots = 7'd4 + n_args[6:0] + n_deps[6:0] + {n_cops[5:0], 1'b0};
  assign last_beat = (k_q == nslots_q - 7'd2);
  assign unused_bits = ^{spawnout_dout[55:0], hdr_q[63:56]};

  // CHECK alternates issue/compare cycles because dout trails addr by one cycle.
  always_comb begin
    wstate_d     = wstate_q;
    hdr_d        = hdr_q;
    nslots_d     = nslots_q;
    k_d          = k_q;
    wr_idx_d     = wr_idx_q;
    chk_pend_d   = chk_pend_q;
    perr_d       = 1'b0;
    so_idx       = wr_idx_q;
    in_ready_c   = 1'b0;
    so_wr_c      = '0;
    spawnout_din = '0;
    unique case (wstate_q)
      W_IDLE: begin
        in_ready_c = 1'b1;
        if (in_valid) begin
          if (hdr_bad) begin
            perr_d = 1'b1;
          end else begin
            hdr_d      = in_data;
            nslots_d   = hdr_slots;
            k_d        = '0;
            chk_pend_d = 1'b0;
            wstate_d   = W_CHECK;
          end
        end
      end
      W_CHECK: begin
        so_idx     = wr_idx_q + OW'(k_q);
        chk_pend_d = 1'b1;
        if (chk_pend_q) begin
          chk_pend_d = 1'b0;
          if (spawnout_dout[63:56] == 8'h00) begin
            if (k_q + 7'd1 == nslots_q) begin
              k_d      = '0;
              wstate_d = W_BODY;
            end else begin
              k_d = k_q + 7'd1;
            end
          end
        end
      end
      W_BODY: begin
        in_ready_c = 1'b1;
        so_idx     = wr_idx_q + OW'(k_q + 7'd1);
        if (in_valid) begin
          so_wr_c      = 8'hFF;
          spawnout_din = in_data;
          if (in_last != last_beat) perr_d = 1'b1;
          if (last_beat) wstate_d = W_HEADER;
          else           k_d      = k_q + 7'd1;
        end
      end
      W_HEADER: begin
        so_idx       = wr_idx_q;
        so_wr_c      = 8'hFF;
        spawnout_din = {8'h80, hdr_q[55:0]};
        wr_idx_d     = wr_idx_q + OW'(nslots_q);
        wstate_d     = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_comb begin
    rstate_d     = rstate_q;
    rd_idx_d     = rd_idx_q;
    tid_d        = tid_q;
    ptid_d       = ptid_q;
    poll_vld_d   = 1'b0;
    si_idx       = rd_idx_q;
    si_wr_c      = '0;
    spawnin_din  = '0;
    cmpl_valid_c = 1'b0;
    unique case (rstate_q)
      R_POLL: begin
        poll_vld_d = 1'b1;
        if (poll_vld_q && spawnin_dout[63:56] == 8'h80) rstate_d = R_TID;
      end
      R_TID: begin
        si_idx   = rd_idx_q + IW'(1);
        rstate_d = R_PTID;
      end
      R_PTID: begin
        si_idx   = rd_idx_q + IW'(2);
        tid_d    = spawnin_dout;
        rstate_d = R_CLEAR;
      end
      R_CLEAR: begin
        si_wr_c  = 8'h80;
        ptid_d   = spawnin_dout;
        rstate_d = R_OUT;
      end
      R_OUT: begin
        cmpl_valid_c = 1'b1;
        if (cmpl_ready) begin
          rd_idx_d = rd_idx_q + IW'(3);
          rstate_d = R_POLL;
        end
      end
      default: rstate_d = R_POLL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wstate_q   <= W_IDLE;
      hdr_q      <= '0;
      nslots_q   <= '0;
      k_q        <= '0;
      wr_idx_q   <= '0;
      chk_pend_q <= 1'b0;
      perr_q     <= 1'b0;
      rstate_q   <= R_POLL;
      rd_idx_q   <= '0;
      tid_q      <= '0;
      ptid_q     <= '0;
      poll_vld_q <= 1'b0;
    end else begin
      wstate_q   <= wstate_d;
      hdr_q      <= hdr_d;
      nslots_q   <= nslots_d;
      k_q        <= k_d;
      wr_idx_q   <= wr_idx_d;
      chk_pend_q <= chk_pend_d;
      perr_q     <= perr_d;
      rstate_q   <= rstate_d;
      rd_idx_q   <= rd_idx_d;
      tid_q      <= tid_d;
      ptid_q     <= ptid_d;
      poll_vld_q <= poll_vld_d;
    end
  end

  assign in_ready      = in_ready_c & ~rst;
  assign proto_err     = perr_q & ~rst;
  assign cmpl_valid    = cmpl_valid_c & ~rst;
  assign cmpl_tid      = tid_q;
  assign cmpl_ptid     = ptid_q;
  assign spawnout_addr = 32'({so_idx, 3'b000});
  assign spawnout_en   = 1'b1;
  assign spawnout_wr   = rst ? 8'h00 : so_wr_c;
  assign spawnin_addr  = 32'({si_idx, 3'b000});
  assign spawnin_en    = 1'b1;
  assign spawnin_wr    = rst ? 8'h00 : si_wr_c;
endmodule

// File: doc/spawn_out_writer.md
SPAWN_OUT_WRITER -- requirements
Module: spawn_out_writer

Interface
REQ-001 SHALL have parameter SPAWNOUT_SIZE, default 1024, spawnout ring depth in 64-bit slots, power of two.
REQ-002 SHALL have parameter SPAWNIN_SIZE, default 1024, spawnin ring depth in 64-bit slots, power of two.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  descriptor beat valid.
REQ-006 in_ready  output  1  descriptor beat accepted when in_valid&in_ready.
REQ-007 in_data  input  64  descriptor beat.
REQ-008 in_last  input  1  producer's marker on final descriptor beat.
REQ-009 cmpl_valid  output  1  completion notification valid.
REQ-010 cmpl_ready  input  1  completion consumed when cmpl_valid&cmpl_ready.
REQ-011 cmpl_tid, cmpl_ptid  output  64 each  completed task id / parent id.
REQ-012 proto_err  output  1  one-cycle pulse on descriptor framing error.
REQ-013 spawnout  MemoryPort32.master  -  addr[31:0], en, wr[7:0] byte enables, din[63:0], dout[63:0]; dout valid one cycle after addr.
REQ-014 spawnin  MemoryPort32.master  -  same fields and latency.

Function
REQ-015 Slot address SHALL be {zeros, idx, 3'b000}; en tied 1; idx wraps modulo ring size.
REQ-016 Entry header bits: valid byte [63:56] (0x80 = valid), num_args [55:48], num_deps [47:40], num_cops [39:32].
REQ-017 Spawnout entry order: header, tid, ptid, task type, deps, copies (2 words each), args; num_slots = 4 + nArgs + nDeps + 2*nCops.
REQ-018 Writer FSM states: IDLE, CHECK, BODY, HEADER.
REQ-019 IDLE: in_ready=1; accepting a beat latches it as header, computes num_slots, k=0, goes CHECK.
REQ-020 CHECK: in_ready=0, wr=0; reads slot wr_idx+k; dout valid byte==0 -> k+1; nonzero -> re-read same slot (poll indefinitely); k reaching num_slots -> BODY.
REQ-021 BODY: in_ready=1; each accepted beat SHALL write all bytes (wr=8'hFF) to wr_idx+1+j, j=0..num_slots-2; no write without a beat.
REQ-022 proto_err SHALL pulse if in_last=1 on a beat with j<num_slots-2, or in_last=0 with j=num_slots-2; count governs, not in_last.
REQ-023 HEADER: single cycle, write latched header with [63:56] forced to 0x80 at wr_idx, then wr_idx += num_slots, go IDLE.
REQ-024 Header SHALL be the last slot written for an entry; body slots never written after header.
REQ-025 nArgs==0 or any count >15 SHALL pulse proto_err in IDLE and drop the header (stay IDLE).
REQ-026 Reader FSM states: POLL, RD_TID, RD_PTID, CLEAR, OUT; independent of writer, may run same cycle.
REQ-027 POLL: read spawnin rd_idx each cycle; valid byte==0x80 -> RD_TID.
REQ-028 RD_TID/RD_PTID: capture dout of slots rd_idx+1, rd_idx+2 into cmpl_tid/cmpl_ptid.
REQ-029 CLEAR: write wr=8'h80, din=0 at rd_idx (clears valid byte only); go OUT.
REQ-030 OUT: cmpl_valid=1, tid/ptid stable until cmpl_ready; on handshake rd_idx += 3, go POLL.
REQ-031 Entries straddling ring end SHALL wrap slot-by-slot without gap.

Reset
REQ-032 rst SHALL force writer IDLE, reader POLL, wr_idx=rd_idx=0, in_ready=0 during rst, cmpl_valid=0, proto_err=0, both wr=0.
REQ-033 rst mid-entry SHALL abandon it with no header write; partial body slots remain stale.
REQ-034 First cycle after rst deassert: in_ready=1.

Verification
REQ-035 Empty rings, header nArgs=1 nDeps=0 nCops=0, 4 beats -> 5 slots written, slot0 = 0x80 in [63:56], header written last, wr_idx=5.
REQ-036 Slot 2 of target range valid byte 0x80 -> CHECK polls slot 2, in_ready=0 until cleared, then proceeds.
REQ-037 wr_idx=SPAWNOUT_SIZE-2, 7-slot entry -> slots 1022,1023,0..4 written, wr_idx=5.
REQ-038 spawnin rd_idx 0 holds {0x8000000000000001, tid=0x11, ptid=0x22} -> cmpl 0x11/0x22, slot0 byte7 cleared, rd_idx=3; cmpl_ready low 10 cycles holds outputs.
REQ-039 Entry nDeps=2 nCops=1 nArgs=2 with in_last on beat 5 of 9 -> proto_err one cycle, entry still 10 slots.
REQ-040 rst asserted in BODY -> no header write, next descriptor lands at slot 0.
